// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counter with byte-enable register writes
// and a maskable level interrupt; reads are combinational on addr.
`default_nettype none

module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL      = 2'd0;
  localparam logic [1:0] A_PRESET    = 2'd1;
  localparam logic [1:0] A_COUNT     = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_t      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;

  logic        ctrl_hit;
  logic        ctrl_wr;
  logic        preset_wr;
  logic [31:0] preset_d;

  // Any enabled lane on CTRL counts as an access (clears irq_flag); only lane 0 holds bits.
  assign ctrl_hit  = we && (addr == A_CTRL) && (|byteen);
  assign ctrl_wr   = ctrl_hit && byteen[0];
  assign preset_wr = we && (addr == A_PRESET) && (|byteen);

  always_comb begin
    preset_d = preset_q;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_q[0]) state_q <= S_LOAD;
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= S_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q    <= 32'd0;
            irq_flag_q <= 1'b1;
            state_q    <= S_INT;
          end
        end
        S_INT: begin
          if (ctrl_q[2:1] == MODE_RELOAD) begin
            irq_flag_q <= 1'b0;
          end else begin
            ctrl_q[0] <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Software writes come last so they override same-cycle FSM updates.
      if (ctrl_wr)   ctrl_q     <= wdata[3:0];
      if (ctrl_hit)  irq_flag_q <= 1'b0;
      if (preset_wr) preset_q   <= preset_d;
    end
  end

  always_comb begin
    case (addr)
      A_CTRL:   rdata = {28'd0, ctrl_q};
      A_PRESET: rdata = preset_q;
      A_COUNT:  rdata = count_q;
      default:  rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed self-checking bench for timer_counter.
`default_nettype none

module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int pass_cnt;
  int total_cnt;

  timer_counter dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    addr   = a;
    we     = 1'b1;
    byteen = be;
    wdata  = d;
    tick();
    we     = 1'b0;
    byteen = 4'd0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick();
    tick();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      total_cnt++;
      if (d !== 32'd0) $display("FAIL reset_rdata[%0d]: got %h want 00000000", a, d);
      else pass_cnt++;
    end
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
    else pass_cnt++;
    reset = 1'b0;
    tick();

    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'h1, 32'h9);
    for (int k = 1; k <= 4; k++) tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd3) $display("FAIL reset_pre_count: got %0d want 3", d);
    else pass_cnt++;

    #1;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_async_irq: got %b want 0", irq);
    else pass_cnt++;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      total_cnt++;
      if (d !== 32'd0) $display("FAIL reset_async_rdata[%0d]: got %h want 00000000", a, d);
      else pass_cnt++;
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd0 || irq !== 1'b0)
      $display("FAIL reset_release_idle: count %0d irq %b want count 0 irq 0", d, irq);
    else pass_cnt++;
  endtask

  task automatic test_byte_merge();
    logic [31:0] d;
    wr(2'd1, 4'hF, 32'hAABBCCDD);
    rd(2'd1, d);
    total_cnt++;
    if (d !== 32'hAABBCCDD) $display("FAIL merge_full: got %h want AABBCCDD", d);
    else pass_cnt++;
    wr(2'd1, 4'h3, 32'h00001122);
    rd(2'd1, d);
    total_cnt++;
    if (d !== 32'hAABB1122) $display("FAIL merge_low2: got %h want AABB1122", d);
    else pass_cnt++;
    wr(2'd1, 4'h0, 32'hFFFFFFFF);
    rd(2'd1, d);
    total_cnt++;
    if (d !== 32'hAABB1122) $display("FAIL merge_none: got %h want AABB1122", d);
    else pass_cnt++;
    wr(2'd1, 4'h4, 32'h00550000);
    rd(2'd1, d);
    total_cnt++;
    if (d !== 32'hAA551122) $display("FAIL merge_lane2: got %h want AA551122", d);
    else pass_cnt++;
    wr(2'd2, 4'hF, 32'h12345678);
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL count_ro: got %h want 00000000", d);
    else pass_cnt++;
    wr(2'd3, 4'hF, 32'h12345678);
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL reserved_ro: got %h want 00000000", d);
    else pass_cnt++;
    wr(2'd0, 4'hF, 32'hFFFFFFF0);
    rd(2'd0, d);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL ctrl_upper: got %h want 00000000", d);
    else pass_cnt++;
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic [31:0] exp_cnt [1:7];
    exp_cnt = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'h1, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick();
      rd(2'd2, d);
      total_cnt++;
      if (d !== exp_cnt[k] || irq !== (k == 7))
        $display("FAIL oneshot_E%0d: count %0d irq %b want count %0d irq %b",
                 k, d, irq, exp_cnt[k], (k == 7));
      else pass_cnt++;
    end
    tick();
    rd(2'd0, d);
    total_cnt++;
    if (d !== 32'h8 || irq !== 1'b1) $display("FAIL oneshot_en_clr: ctrl %h irq %b want 8 1", d, irq);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL oneshot_hold: got %b want 1", irq);
    else pass_cnt++;
    wr(2'd0, 4'h1, 32'h8);
    rd(2'd0, d);
    total_cnt++;
    if (irq !== 1'b0 || d !== 32'h8) $display("FAIL oneshot_ack: irq %b ctrl %h want 0 8", irq, d);
    else pass_cnt++;
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    logic        saw_irq, saw0, saw2;
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'h1, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick();
      total_cnt++;
      if (irq !== (k == 4 || k == 9 || k == 14))
        $display("FAIL reload_E%0d: irq %b want %b", k, irq, (k == 4 || k == 9 || k == 14));
      else pass_cnt++;
    end
    wr(2'd0, 4'h1, 32'h3);
    saw_irq = 1'b0;
    saw0 = 1'b0;
    saw2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      rd(2'd2, d);
      if (irq) saw_irq = 1'b1;
      if (d == 32'd0) saw0 = 1'b1;
      if (d == 32'd2) saw2 = 1'b1;
    end
    total_cnt++;
    if (saw_irq !== 1'b0) $display("FAIL reload_masked_irq: got %b want 0", saw_irq);
    else pass_cnt++;
    total_cnt++;
    if ((saw0 && saw2) !== 1'b1) $display("FAIL reload_masked_cycles: saw0 %b saw2 %b want 1 1", saw0, saw2);
    else pass_cnt++;
    wr(2'd0, 4'h1, 32'h0);
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_disable();
    logic [31:0] d;
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'h1, 32'h9);
    for (int k = 1; k <= 6; k++) tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd6) $display("FAIL dis_pre: got %0d want 6", d);
    else pass_cnt++;
    wr(2'd0, 4'h1, 32'h0);
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd5) $display("FAIL dis_write_edge: got %0d want 5", d);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd5 || irq !== 1'b0) $display("FAIL dis_frozen: count %0d irq %b want 5 0", d, irq);
    else pass_cnt++;
    wr(2'd0, 4'h1, 32'h9);
    tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd5) $display("FAIL reen_load: got %0d want 5", d);
    else pass_cnt++;
    tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd10) $display("FAIL reen_reload: got %0d want 10", d);
    else pass_cnt++;
    wr(2'd0, 4'h1, 32'h0);
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(2'd1, 4'hF, 32'd3);
    wr(2'd0, 4'h1, 32'h9);
    for (int k = 1; k <= 5; k++) tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL coll_expire: irq %b want 1", irq);
    else pass_cnt++;
    wr(2'd0, 4'h1, 32'h9);
    rd(2'd0, d);
    total_cnt++;
    if (d !== 32'h9 || irq !== 1'b0) $display("FAIL coll_write_wins: ctrl %h irq %b want 9 0", d, irq);
    else pass_cnt++;
    tick();
    tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd3) $display("FAIL coll_restart: count %0d want 3", d);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) tick();
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'd0 || irq !== 1'b1) $display("FAIL coll_reexpire: count %0d irq %b want 0 1", d, irq);
    else pass_cnt++;
    wr(2'd0, 4'h1, 32'h0);
    tick();
  endtask

  task automatic test_preset_zero();
    wr(2'd1, 4'hF, 32'd0);
    wr(2'd0, 4'h1, 32'h9);
    tick();
    tick();
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL p0_E2: irq %b want 0", irq);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL p0_E3: irq %b want 1", irq);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset  = 1'b1;
    addr   = 2'd0;
    we     = 1'b0;
    byteen = 4'd0;
    wdata  = 32'd0;
    test_reset();
    test_byte_merge();
    test_one_shot();
    test_auto_reload();
    test_disable();
    test_back_to_back();
    test_preset_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counter with interrupt output, sitting directly downstream of the store byte-enable stage behind the system bridge. It consumes the word-aligned write data and 4-bit byte enables that the store path produces, merges them into its registers, and raises an interrupt request to the CP0 when a programmed count expires. Reads are combinational so the bridge can return load data in the same cycle.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- addr  in  2  word offset within the device (byte address bits [3:2])
- we  in  1  write strobe from the bridge (device selected and store in M stage)
- byteen  in  4  per-byte write enables, bit i covers wdata[8i+7:8i]
- wdata  in  32  lane-aligned store data
- rdata  out  32  register read data, combinational on addr
- irq  out  1  interrupt request, level

## Operation
- Registers: offset 0 CTRL, offset 1 PRESET, offset 2 COUNT (read-only), offset 3 reserved.
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1 = enabled); bits [31:4] not stored, read 0.
- A write occurs when we=1; each byte lane i of the target register updates only if byteen[i]=1. byteen=0000 with we=1 is a no-op. Writes to COUNT and offset 3 are ignored.
- rdata: offset 0 -> {28'b0, CTRL[3:0]}; 1 -> PRESET; 2 -> COUNT; 3 -> 0.
- FSM states IDLE, LOAD, CNT, INT; transitions use register values before the current edge:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: EN=0 -> IDLE (COUNT holds). Else COUNT>1 -> COUNT-1, stay. Else COUNT <= 0, irq_flag <= 1, -> INT.
  - INT: MODE 00 -> EN cleared, -> IDLE, irq_flag held. MODE 01 -> EN untouched, irq_flag cleared, -> IDLE (reloads next cycle).
- irq = irq_flag & CTRL[3].
- irq_flag is also cleared by any effective write to CTRL (any byteen bit set, addr=0).
- Simultaneous software write and FSM update to the same register bit: software write wins (e.g. CTRL write in INT cycle keeps the written EN).
- PRESET written during CNT affects only the next LOAD.
- PRESET=0 or 1: LOAD loads it, CNT sees COUNT<=1, expires on the following edge.
- Reset mid-count: state IDLE, all registers 0, irq drops asynchronously.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0, irq=0, rdata=0 for addr 0–3.
- Write latency: register visible on rdata the cycle after the write edge.
- Enabling write at edge E0: LOAD after E1, COUNT=PRESET after E2, COUNT=0 and irq high after edge E(PRESET+2) for PRESET>=1.
- Auto-reload period: PRESET+3 cycles between irq pulses; irq high exactly one cycle per period.
- One-shot: irq stays high until CTRL write or reset; EN reads 0 one cycle after irq rises.
- Clearing EN during CNT: state IDLE after the edge following the write edge.

## Test plan
- Reset: assert reset mid-count with COUNT=3 -> irq, rdata (all addr) read 0 immediately; state IDLE after release.
- Byte merge: write PRESET=0xAABBCCDD byteen=1111, then wdata=0x00001122 byteen=0011 -> PRESET reads 0xAABB1122; byteen=0000 write -> unchanged.
- One-shot: PRESET=5, CTRL=0x9 -> COUNT 5,4,3,2,1,0, irq rises 7 edges after enabling write, CTRL reads 0x8, irq held until CTRL write 0x8 clears it.
- Auto-reload: PRESET=2, CTRL=0xB -> single-cycle irq pulses every 5 cycles; IM=0 (CTRL=0x3) -> irq stays 0 while COUNT still cycles.
- Disable mid-count: PRESET=10, enable, write CTRL=0x0 when COUNT=6 -> COUNT freezes at 5 or 6 per edge order, no irq; re-enable reloads 10.
- Collision: one-shot expiring, CTRL write 0x9 in INT cycle -> EN stays 1, irq_flag cleared, counter restarts from PRESET.
